uart_cmd_assembler: RTL and testbench

Byte-to-command assembler sitting directly downstream of the UART receiver. Consumes each received byte via the receiver's `rdy`/`clr_rdy` handshake and pairs consecutive bytes (high byte first) into a 16-bit command. Presents the command to the command processor with a level `cmd_rdy` flag. An inter-byte timeout discards a stranded high byte so a lost byte cannot permanently misalign framing.

---
 rtl/uart_cmd_assembler.sv | 103 ++++++++++
 tb/tb_uart_cmd_assembler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// Pairs consecutive UART bytes (high byte first) into 16-bit commands.
// A stranded high byte is dropped after TO_CYCLES idle cycles.
module uart_cmd_assembler #(
    parameter int TO_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        timeout_err,
    output logic        overrun
);

    localparam logic [15:0] TO_INIT = 16'(TO_CYCLES - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  hi_byte;
    logic [15:0] to_cnt;
    logic        load_hi;
    logic        complete;
    logic        expire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A byte arriving on the same cycle the counter hits zero takes priority.
    always_comb begin
        state_next = state;
        load_hi    = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        clr_rx_rdy = rx_rdy;
        case (state)
            IDLE: begin
                if (rx_rdy) begin
                    load_hi    = 1'b1;
                    state_next = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (rx_rdy) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (to_cnt == 16'd0) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte <= 8'h00;
            to_cnt  <= 16'd0;
        end else begin
            if (load_hi) begin
                hi_byte <= rx_data;
                to_cnt  <= TO_INIT;
            end else if (expire) begin
                hi_byte <= 8'h00;
            end else if (state == WAIT_LOW && !rx_rdy && to_cnt != 16'd0) begin
                to_cnt <= to_cnt - 16'd1;
            end
        end
    end

    // Completion sets cmd_rdy even when the consumer acknowledges on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd         <= 16'h0000;
            cmd_rdy     <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            timeout_err <= expire;
            overrun     <= complete && cmd_rdy && !clr_cmd_rdy;
            if (complete) begin
                cmd     <= {hi_byte, rx_data};
                cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Scoreboard bench: instance a uses the default timeout, instance b a 20-cycle timeout.
module tb_uart_cmd_assembler;

    localparam int TO_B = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_rdy_a = 1'b0, rx_rdy_b = 1'b0;
    logic [7:0]  rx_data_a = 8'h00, rx_data_b = 8'h00;
    logic        clr_cmd_rdy_a = 1'b0, clr_cmd_rdy_b = 1'b0;
    logic        clr_rx_rdy_a, clr_rx_rdy_b;
    logic [15:0] cmd_a, cmd_b;
    logic        cmd_rdy_a, cmd_rdy_b;
    logic        timeout_err_a, timeout_err_b;
    logic        overrun_a, overrun_b;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    uart_cmd_assembler dut_a (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy_a), .rx_data(rx_data_a),
        .clr_rx_rdy(clr_rx_rdy_a), .clr_cmd_rdy(clr_cmd_rdy_a), .cmd(cmd_a),
        .cmd_rdy(cmd_rdy_a), .timeout_err(timeout_err_a), .overrun(overrun_a)
    );

    uart_cmd_assembler #(.TO_CYCLES(TO_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy_b), .rx_data(rx_data_b),
        .clr_rx_rdy(clr_rx_rdy_b), .clr_cmd_rdy(clr_cmd_rdy_b), .cmd(cmd_b),
        .cmd_rdy(cmd_rdy_b), .timeout_err(timeout_err_b), .overrun(overrun_b)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_a(input logic [7:0] d);
        @(negedge clk);
        rx_rdy_a = 1'b1;
        rx_data_a = d;
        checks++;
        if (clr_rx_rdy_a !== 1'b1) begin
            failures++;
            $display("FAIL clr_rx_rdy_a: got %b want 1", clr_rx_rdy_a);
        end
        @(posedge clk);
        #1 rx_rdy_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d, input logic ack);
        @(negedge clk);
        rx_rdy_b = 1'b1;
        rx_data_b = d;
        clr_cmd_rdy_b = ack;
        checks++;
        if (clr_rx_rdy_b !== 1'b1) begin
            failures++;
            $display("FAIL clr_rx_rdy_b: got %b want 1", clr_rx_rdy_b);
        end
        @(posedge clk);
        #1;
        rx_rdy_b = 1'b0;
        clr_cmd_rdy_b = 1'b0;
    endtask

    task automatic check_cmd_b(input string name, input logic want_ovr);
        logic [15:0] exp;
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty, got cmd %h", name, cmd_b);
        end else begin
            exp = exp_q.pop_front();
            if (cmd_b !== exp) begin
                failures++;
                $display("FAIL %s cmd: got %h want %h", name, cmd_b, exp);
            end
        end
        checks++;
        if (cmd_rdy_b !== 1'b1) begin
            failures++;
            $display("FAIL %s cmd_rdy: got %b want 1", name, cmd_rdy_b);
        end
        checks++;
        if (overrun_b !== want_ovr) begin
            failures++;
            $display("FAIL %s overrun: got %b want %b", name, overrun_b, want_ovr);
        end
        checks++;
        if (timeout_err_b !== 1'b0) begin
            failures++;
            $display("FAIL %s timeout_err: got %b want 0", name, timeout_err_b);
        end
    endtask

    task automatic ack_b();
        @(negedge clk);
        clr_cmd_rdy_b = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy_b = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_rdy_b !== 1'b0) begin
            failures++;
            $display("FAIL ack_b cmd_rdy: got %b want 0", cmd_rdy_b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd_a, cmd_rdy_a, timeout_err_a, overrun_a} !== 19'h0) begin
            failures++;
            $display("FAIL reset_a: got cmd=%h rdy=%b to=%b ov=%b want 0", cmd_a, cmd_rdy_a, timeout_err_a, overrun_a);
        end
        checks++;
        if ({cmd_b, cmd_rdy_b, timeout_err_b, overrun_b} !== 19'h0) begin
            failures++;
            $display("FAIL reset_b: got cmd=%h rdy=%b to=%b ov=%b want 0", cmd_b, cmd_rdy_b, timeout_err_b, overrun_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if ({clr_rx_rdy_a, clr_rx_rdy_b} !== 2'b00) begin
                failures++;
                $display("FAIL idle_clr_rx_rdy cycle %0d: got %b%b want 00", i, clr_rx_rdy_a, clr_rx_rdy_b);
            end
            checks++;
            if ({cmd_a, cmd_rdy_a, timeout_err_a, overrun_a, cmd_b, cmd_rdy_b, timeout_err_b, overrun_b} !== 38'h0) begin
                failures++;
                $display("FAIL idle_outputs cycle %0d: got cmd_a=%h cmd_b=%h flags nonzero", i, cmd_a, cmd_b);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp;
        send_a(8'hA5);
        repeat (999) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cmd_rdy_a !== 1'b0 || cmd_a !== 16'h0000 || timeout_err_a !== 1'b0) begin
            failures++;
            $display("FAIL basic_wait: got cmd=%h rdy=%b to=%b want 0000/0/0", cmd_a, cmd_rdy_a, timeout_err_a);
        end
        exp_q.push_back(16'hA53C);
        send_a(8'h3C);
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (cmd_a !== exp || cmd_rdy_a !== 1'b1) begin
            failures++;
            $display("FAIL basic_cmd: got cmd=%h rdy=%b want %h/1", cmd_a, cmd_rdy_a, exp);
        end
        clr_cmd_rdy_a = 1'b1;
        @(posedge clk);
        #1 clr_cmd_rdy_a = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_rdy_a !== 1'b0 || cmd_a !== 16'hA53C) begin
            failures++;
            $display("FAIL basic_ack: got cmd=%h rdy=%b want a53c/0", cmd_a, cmd_rdy_a);
        end
    endtask

    task automatic test_timeout();
        send_b(8'h12, 1'b0);
        for (int i = 1; i <= TO_B + 2; i++) begin
            @(negedge clk);
            checks++;
            if (timeout_err_b !== (i == TO_B + 1)) begin
                failures++;
                $display("FAIL timeout_pulse cycle %0d: got %b want %b", i, timeout_err_b, (i == TO_B + 1));
            end
        end
        checks++;
        if (cmd_b !== 16'h0000 || cmd_rdy_b !== 1'b0) begin
            failures++;
            $display("FAIL timeout_cmd_hold: got cmd=%h rdy=%b want 0000/0", cmd_b, cmd_rdy_b);
        end
        send_b(8'h34, 1'b0);
        exp_q.push_back(16'h3456);
        send_b(8'h56, 1'b0);
        check_cmd_b("timeout_realign", 1'b0);
        ack_b();
    endtask

    task automatic test_boundary();
        send_b(8'hAB, 1'b0);
        repeat (TO_B - 1) @(posedge clk);
        exp_q.push_back(16'hABCD);
        send_b(8'hCD, 1'b0);
        check_cmd_b("boundary_last_cycle", 1'b0);
        @(negedge clk);
        checks++;
        if (timeout_err_b !== 1'b0) begin
            failures++;
            $display("FAIL boundary_no_timeout: got %b want 0", timeout_err_b);
        end
        ack_b();
        send_b(8'h11, 1'b0);
        repeat (TO_B) @(posedge clk);
        @(negedge clk);
        rx_rdy_b = 1'b1;
        rx_data_b = 8'h22;
        checks++;
        if (timeout_err_b !== 1'b1) begin
            failures++;
            $display("FAIL late_timeout: got %b want 1", timeout_err_b);
        end
        @(posedge clk);
        #1 rx_rdy_b = 1'b0;
        @(negedge clk);
        checks++;
        if (timeout_err_b !== 1'b0 || cmd_rdy_b !== 1'b0 || cmd_b !== 16'hABCD) begin
            failures++;
            $display("FAIL late_after: got to=%b rdy=%b cmd=%h want 0/0/abcd", timeout_err_b, cmd_rdy_b, cmd_b);
        end
        exp_q.push_back(16'h2233);
        send_b(8'h33, 1'b0);
        check_cmd_b("late_byte_as_high", 1'b0);
        ack_b();
    endtask

    task automatic test_overrun();
        send_b(8'h01, 1'b0);
        exp_q.push_back(16'h0102);
        send_b(8'h02, 1'b0);
        check_cmd_b("overrun_first", 1'b0);
        send_b(8'h03, 1'b0);
        exp_q.push_back(16'h0304);
        send_b(8'h04, 1'b0);
        check_cmd_b("overrun_second", 1'b1);
        @(negedge clk);
        checks++;
        if (overrun_b !== 1'b0) begin
            failures++;
            $display("FAIL overrun_one_cycle: got %b want 0", overrun_b);
        end
        send_b(8'h05, 1'b0);
        exp_q.push_back(16'h0506);
        send_b(8'h06, 1'b1);
        check_cmd_b("set_wins_over_clear", 1'b0);
    endtask

    task automatic test_reset_mid();
        send_b(8'h77, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_b, cmd_rdy_b, timeout_err_b, overrun_b} !== 19'h0) begin
            failures++;
            $display("FAIL reset_mid: got cmd=%h rdy=%b to=%b ov=%b want 0", cmd_b, cmd_rdy_b, timeout_err_b, overrun_b);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < TO_B + 5; i++) begin
            @(negedge clk);
            checks++;
            if (timeout_err_b !== 1'b0 || cmd_rdy_b !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_quiet cycle %0d: got to=%b rdy=%b want 0/0", i, timeout_err_b, cmd_rdy_b);
            end
        end
        send_b(8'hFF, 1'b0);
        exp_q.push_back(16'hFF00);
        send_b(8'h00, 1'b0);
        check_cmd_b("after_reset", 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_boundary();
        test_overrun();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d leftover want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
